btn_conditioner: RTL and testbench



---
 rtl/btn_conditioner.sv | 141 ++++++++++++++
 tb/tb_btn_conditioner.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button front end: per-channel synchroniser, debouncer, press/release
// pulse generator and optional hold-to-auto-repeat on the press pulse.
module btn_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic               clk_50,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = (RP_MAX > 2) ? $clog2(RP_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RATE  = 2'd2
  } rep_state_t;

  logic [NUM_BTN-1:0] pin;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] level_d;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] fall;
  logic [NUM_BTN-1:0] rep_fire;

  assign pin  = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
  assign rise = btn_level & ~level_d;
  assign fall = ~btn_level & level_d;

  // Pulses are registered so consumers see them one cycle after the level edge.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      level_d     <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      sync1       <= pin;
      sync2       <= sync1;
      level_d     <= btn_level;
      btn_press   <= rise | rep_fire;
      btn_release <= fall;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    logic            level_q;
    logic [DB_W-1:0] db_cnt;
    rep_state_t      state_q;
    rep_state_t      state_n;
    logic [RP_W-1:0] rcnt_q;
    logic [RP_W-1:0] rcnt_n;
    logic            fire;

    assign btn_level[g] = level_q;
    assign rep_fire[g]  = fire;

    always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
        level_q <= 1'b0;
        db_cnt  <= '0;
      end else if (sync2[g] == level_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= ~level_q;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end

    always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        rcnt_q  <= '0;
      end else begin
        state_q <= state_n;
        rcnt_q  <= rcnt_n;
      end
    end

    // Leaving IDLE on the same edge that registers the press pulse makes the
    // first repeat land exactly REPEAT_DELAY cycles after that pulse.
    always_comb begin
      state_n = state_q;
      rcnt_n  = rcnt_q;
      fire    = 1'b0;
      if (!level_q) begin
        state_n = IDLE;
        rcnt_n  = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise[g]) begin
              state_n = DELAY;
              rcnt_n  = '0;
            end
          end
          DELAY: begin
            if (!repeat_en[g]) begin
              rcnt_n = '0;
            end else if (rcnt_q == RP_W'(REPEAT_DELAY - 1)) begin
              fire    = 1'b1;
              rcnt_n  = '0;
              state_n = RATE;
            end else begin
              rcnt_n = rcnt_q + RP_W'(1);
            end
          end
          RATE: begin
            if (!repeat_en[g]) begin
              rcnt_n = '0;
            end else if (rcnt_q == RP_W'(REPEAT_RATE - 1)) begin
              fire   = 1'b1;
              rcnt_n = '0;
            end else begin
              rcnt_n = rcnt_q + RP_W'(1);
            end
          end
          default: begin
            state_n = IDLE;
            rcnt_n  = '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timings;
// expected pulse positions are hand-derived edge numbers after each stimulus.
module tb_btn_conditioner;

  localparam int NB = 3;

  logic          clk_50 = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] repeat_en;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int n_checks = 0;
  int n_pass   = 0;

  btn_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .clk_50     (clk_50),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk_50 = ~clk_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Advance one active edge and sample just after it.
  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Edge k (counted from a stimulus change) on which channel 2 emits a press
  // pulse while held with repeat enabled: initial at 7, then 17, 20, 23, ...
  function automatic logic rep_pulse(input int k);
    return (k == 7) || (k >= 17 && ((k - 17) % 3) == 0);
  endfunction

  initial begin
    rst       = 1'b1;
    btn_raw   = 3'b111;
    repeat_en = 3'b100;
    idle(3);
    check("rst_level",   32'(btn_level),   32'd0);
    check("rst_press",   32'(btn_press),   32'd0);
    check("rst_release", 32'(btn_release), 32'd0);
    @(negedge clk_50);
    rst = 1'b0;
    idle(8);
    check("idle_level", 32'(btn_level), 32'd0);

    // Clean press on channel 0, repeat disabled there.
    @(negedge clk_50);
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      check("press0_level",   32'(btn_level),   32'((k >= 6) ? 3'b001 : 3'b000));
      check("press0_press",   32'(btn_press),   32'((k == 7) ? 3'b001 : 3'b000));
      check("press0_release", 32'(btn_release), 32'd0);
    end

    // Release channel 0.
    @(negedge clk_50);
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("rel0_level",   32'(btn_level),   32'((k < 6) ? 3'b001 : 3'b000));
      check("rel0_release", 32'(btn_release), 32'((k == 7) ? 3'b001 : 3'b000));
      check("rel0_press",   32'(btn_press),   32'd0);
    end

    // Bounce on channel 1: pressed/released in 3-cycle bursts, then released.
    for (int ph = 0; ph < 4; ph++) begin
      @(negedge clk_50);
      btn_raw[1] = ph[0];
      for (int k = 0; k < 3; k++) begin
        step();
        check("bounce_level",   32'(btn_level),   32'd0);
        check("bounce_press",   32'(btn_press),   32'd0);
        check("bounce_release", 32'(btn_release), 32'd0);
      end
    end
    for (int k = 0; k < 10; k++) begin
      step();
      check("bounce_settle", 32'({btn_level, btn_press, btn_release}), 32'd0);
    end

    // Auto-repeat on channel 2; raw released after edge 47, so the level
    // falls at edge 53 and the repeat due on that same edge still fires.
    @(negedge clk_50);
    btn_raw[2] = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      step();
      check("rep_level",   32'(btn_level),   32'((k >= 6 && k < 53) ? 3'b100 : 3'b000));
      check("rep_press",   32'(btn_press),   32'((rep_pulse(k) && k <= 53) ? 3'b100 : 3'b000));
      check("rep_release", 32'(btn_release), 32'((k == 54) ? 3'b100 : 3'b000));
      if (k == 47) begin
        @(negedge clk_50);
        btn_raw[2] = 1'b1;
      end
    end

    // Simultaneous press and release of all three channels.
    repeat_en = 3'b000;
    @(negedge clk_50);
    btn_raw = 3'b000;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("sim_level", 32'(btn_level), 32'((k >= 6) ? 3'b111 : 3'b000));
      check("sim_press", 32'(btn_press), 32'((k == 7) ? 3'b111 : 3'b000));
    end
    @(negedge clk_50);
    btn_raw = 3'b111;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("sim_release", 32'(btn_release), 32'((k == 7) ? 3'b111 : 3'b000));
      check("sim_press0",  32'(btn_press),   32'd0);
    end

    // Reset in the middle of a repeat run on channel 2.
    repeat_en = 3'b100;
    idle(4);
    @(negedge clk_50);
    btn_raw[2] = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step();
      check("pre_rst_press", 32'(btn_press), 32'(rep_pulse(k) ? 3'b100 : 3'b000));
    end
    check("pre_rst_level", 32'(btn_level), 32'(3'b100));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_level",   32'(btn_level),   32'd0);
    check("async_rst_press",   32'(btn_press),   32'd0);
    check("async_rst_release", 32'(btn_release), 32'd0);
    idle(2);
    @(negedge clk_50);
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      check("post_rst_level", 32'(btn_level), 32'((k >= 6) ? 3'b100 : 3'b000));
      check("post_rst_press", 32'(btn_press), 32'(rep_pulse(k) ? 3'b100 : 3'b000));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
